// File: rtl/cam_stream_source.sv
// rtl/cam_stream_source.sv - camera pixel bus to packetised video stream with show-ahead FIFO
module cam_stream_source #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int FIFO_DEPTH   = 16,
  parameter int DATA_WIDTH   = 30
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  cam_frame_valid,
  input  logic                  cam_pixel_valid,
  input  logic [DATA_WIDTH-1:0] cam_pixel_data,
  output logic                  src_startofpacket,
  output logic                  src_endofpacket,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic [DATA_WIDTH-1:0] src_data,
  input  logic                  clear_status,
  output logic                  overflow,
  output logic                  frame_error
);

  localparam int TOTAL = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int EW    = DATA_WIDTH + 2;

  localparam logic [CW-1:0] LAST_PIX = CW'(TOTAL - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [AW:0]   PTR_ONE  = (AW + 1)'(1);

  typedef enum logic [2:0] {
    WAIT_LOW,
    ARMED,
    STREAM,
    CLOSE,
    WAIT_END
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          complete;
  logic          cam_frame_valid_d;

  // Each FIFO entry is {data, sop, eop}
  logic [EW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          full;
  logic          empty;
  logic          pop;
  logic [EW-1:0] head;

  logic          pixel;
  logic          rise;
  logic          capture;
  logic          wr_en;
  logic [EW-1:0] wr_word;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];
  assign pop   = !empty && src_ready;

  // Head entry is presented directly; blanked while the FIFO is empty
  assign src_valid         = !empty;
  assign src_data          = empty ? '0 : head[EW-1:2];
  assign src_startofpacket = !empty && head[1];
  assign src_endofpacket   = !empty && head[0];

  // Decode the FIFO write for this cycle: a captured pixel or the closing filler beat
  always_comb begin
    pixel   = cam_frame_valid && cam_pixel_valid;
    rise    = cam_frame_valid && !cam_frame_valid_d;
    capture = (state == STREAM) || ((state == ARMED) && rise);
    wr_en   = 1'b0;
    wr_word = '0;
    if (capture && pixel && !full) begin
      wr_en   = 1'b1;
      wr_word = {cam_pixel_data, (count == '0), (count == LAST_PIX)};
    end else if ((state == CLOSE) && !full) begin
      wr_en   = 1'b1;
      wr_word = {{DATA_WIDTH{1'b0}}, 1'b0, 1'b1};
    end
  end

  // FIFO storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk_clk) begin
    if (wr_en) begin
      mem[wr_ptr[AW-1:0]] <= wr_word;
    end
  end

  // Write pointer advances on every accepted write
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      wr_ptr <= '0;
    end else if (wr_en) begin
      wr_ptr <= wr_ptr + PTR_ONE;
    end
  end

  // Read pointer advances when the sink takes the head beat
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rd_ptr <= '0;
    end else if (pop) begin
      rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Frame tracking FSM, pixel counter and sticky status flags (a set beats a same-cycle clear)
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state             <= WAIT_LOW;
      count             <= '0;
      complete          <= 1'b0;
      cam_frame_valid_d <= 1'b1;
      overflow          <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      cam_frame_valid_d <= cam_frame_valid;
      if (clear_status) begin
        overflow    <= 1'b0;
        frame_error <= 1'b0;
      end
      case (state)
        WAIT_LOW: begin
          if (!cam_frame_valid) begin
            state <= ARMED;
          end
        end
        ARMED, STREAM: begin
          if (capture) begin
            if (pixel) begin
              if (full) begin
                overflow <= 1'b1;
                state    <= CLOSE;
              end else if (count == LAST_PIX) begin
                count    <= '0;
                complete <= 1'b1;
                state    <= WAIT_END;
              end else begin
                count <= count + CNT_ONE;
                state <= STREAM;
              end
            end else if (!cam_frame_valid) begin
              if (count != '0) begin
                frame_error <= 1'b1;
                state       <= CLOSE;
              end else begin
                state <= ARMED;
              end
            end else begin
              state <= STREAM;
            end
          end
        end
        CLOSE: begin
          if (!full) begin
            count    <= '0;
            complete <= 1'b0;
            state    <= WAIT_END;
          end
        end
        WAIT_END: begin
          if (pixel && complete) begin
            frame_error <= 1'b1;
          end
          if (!cam_frame_valid) begin
            state <= ARMED;
          end
        end
        default: begin
          state <= WAIT_LOW;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_stream_source.sv
// tb/tb_cam_stream_source.sv - self-checking bench for cam_stream_source
module tb_cam_stream_source;

  localparam int FW    = 4;
  localparam int FH    = 2;
  localparam int TOTAL = FW * FH;
  localparam int DEPTH = 4;
  localparam int DW    = 30;

  localparam int M_IDLE    = 0;
  localparam int M_CAPTURE = 1;
  localparam int M_CLOSING = 2;
  localparam int M_DROP    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          fv;
  logic          pv;
  logic [DW-1:0] pd;
  logic          rdy;
  logic          clr;
  logic          sop;
  logic          eop;
  logic          valid;
  logic [DW-1:0] data;
  logic          ov;
  logic          fe;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_rdy = 1'b0;

  // Reference: expected FIFO content as a queue of {data, sop, eop}, plus frame bookkeeping
  logic [31:0] q[$];
  logic [31:0] got[$];
  int          mode;
  int          npix;
  bit          complete;
  bit          prev_fv;
  bit          m_ov;
  bit          m_fe;

  cam_stream_source #(
    .FRAME_WIDTH (FW),
    .FRAME_HEIGHT(FH),
    .FIFO_DEPTH  (DEPTH),
    .DATA_WIDTH  (DW)
  ) dut (
    .clk_clk          (clk),
    .reset_reset      (rst),
    .cam_frame_valid  (fv),
    .cam_pixel_valid  (pv),
    .cam_pixel_data   (pd),
    .src_startofpacket(sop),
    .src_endofpacket  (eop),
    .src_valid        (valid),
    .src_ready        (rdy),
    .src_data         (data),
    .clear_status     (clr),
    .overflow         (ov),
    .frame_error      (fe)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] beat(input int d, input bit s, input bit e);
    logic [DW-1:0] dd;
    dd = DW'(d);
    return {dd, s, e};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    mode     = M_DROP;
    npix     = 0;
    complete = 1'b0;
    prev_fv  = 1'b1;
    m_ov     = 1'b0;
    m_fe     = 1'b0;
  endtask

  // One clock of the frame rules: a frame opens on a rising frame_valid edge while idle
  task automatic model_step();
    bit pixel;
    bit is_full;
    bit do_pop;
    pixel   = fv && pv;
    is_full = (q.size() == DEPTH);
    do_pop  = (q.size() != 0) && rdy;
    if (clr) begin
      m_ov = 1'b0;
      m_fe = 1'b0;
    end
    if (mode == M_IDLE && fv && !prev_fv) begin
      mode = M_CAPTURE;
      npix = 0;
    end
    if (mode == M_CAPTURE) begin
      if (pixel) begin
        if (is_full) begin
          m_ov = 1'b1;
          mode = M_CLOSING;
        end else begin
          q.push_back({pd, 1'(npix == 0), 1'(npix == TOTAL - 1)});
          npix++;
          if (npix == TOTAL) begin
            mode     = M_DROP;
            complete = 1'b1;
          end
        end
      end else if (!fv) begin
        if (npix > 0) begin
          m_fe = 1'b1;
          mode = M_CLOSING;
        end else begin
          mode = M_IDLE;
        end
      end
    end else if (mode == M_CLOSING) begin
      if (!is_full) begin
        q.push_back(beat(0, 1'b0, 1'b1));
        mode     = M_DROP;
        complete = 1'b0;
      end
    end else if (mode == M_DROP) begin
      if (pixel && complete) m_fe = 1'b1;
      if (!fv) mode = M_IDLE;
    end
    if (do_pop) void'(q.pop_front());
    prev_fv = fv;
  endtask

  // Advance one clock, record accepted beats, step the reference and compare all outputs
  task automatic cycle();
    if (rnd_rdy) rdy = 1'($urandom_range(0, 1));
    if (valid && rdy) got.push_back({data, sop, eop});
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #1;
    chk("src_valid", 32'(valid), 32'(q.size() != 0));
    if (q.size() != 0) chk("src_beat", {data, sop, eop}, q[0]);
    else               chk("idle_beat", {data, sop, eop}, 32'd0);
    chk("overflow", 32'(ov), 32'(m_ov));
    chk("frame_error", 32'(fe), 32'(m_fe));
  endtask

  task automatic idle(input int n);
    pv = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic run_frame(input int n, input bit directed, input int max_gap, input bit keep_high);
    fv = 1'b1;
    if (n == 0) begin
      pv = 1'b0;
      cycle();
    end
    for (int i = 0; i < n; i++) begin
      pv = 1'b1;
      pd = directed ? DW'(i + 1) : DW'($urandom);
      cycle();
      if (max_gap > 0) begin
        int g;
        g = $urandom_range(0, max_gap);
        for (int k = 0; k < g; k++) begin
          pv = 1'b0;
          pd = DW'($urandom);
          cycle();
        end
      end
    end
    pv = 1'b0;
    if (!keep_high) fv = 1'b0;
  endtask

  task automatic pulse_clear();
    clr = 1'b1;
    cycle();
    clr = 1'b0;
  endtask

  task automatic check_full_packet(input string tag);
    chk({tag, "_beats"}, 32'(got.size()), 32'(TOTAL));
    for (int i = 0; i < TOTAL && i < int'(got.size()); i++)
      chk({tag, "_beat"}, got[i], beat(i + 1, i == 0, i == TOTAL - 1));
  endtask

  initial begin
    rst = 1'b1;
    fv  = 1'b1;
    pv  = 1'b0;
    pd  = '0;
    rdy = 1'b1;
    clr = 1'b0;
    model_reset();
    #12;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_sop", 32'(sop), 32'd0);
    chk("rst_eop", 32'(eop), 32'd0);
    chk("rst_data", 32'(data), 32'd0);
    chk("rst_overflow", 32'(ov), 32'd0);
    chk("rst_frame_error", 32'(fe), 32'd0);
    rst = 1'b0;

    // Frame already running at reset release is ignored
    pv = 1'b1;
    pd = DW'(30'h77);
    repeat (3) cycle();
    chk("inflight_ignored", 32'(got.size()), 32'd0);
    fv = 1'b0;
    idle(2);

    // Normal frame
    got.delete();
    run_frame(8, 1'b1, 0, 1'b0);
    idle(6);
    check_full_packet("normal");
    chk("normal_ov", 32'(ov), 32'd0);
    chk("normal_fe", 32'(fe), 32'd0);

    // Backpressure overflow
    got.delete();
    rdy = 1'b0;
    run_frame(5, 1'b1, 0, 1'b1);
    chk("ovf_flag", 32'(ov), 32'd1);
    chk("ovf_held_head", {data, sop, eop}, beat(1, 1'b1, 1'b0));
    rdy = 1'b1;
    idle(8);
    fv = 1'b0;
    idle(3);
    chk("ovf_beats", 32'(got.size()), 32'd5);
    for (int i = 0; i < 4 && i < int'(got.size()); i++)
      chk("ovf_beat", got[i], beat(i + 1, i == 0, 1'b0));
    if (got.size() > 4) chk("ovf_filler", got[4], beat(0, 1'b0, 1'b1));
    chk("ovf_fe", 32'(fe), 32'd0);
    pulse_clear();
    chk("ovf_cleared", 32'(ov), 32'd0);

    // Short frame
    got.delete();
    run_frame(5, 1'b1, 0, 1'b0);
    idle(5);
    chk("short_beats", 32'(got.size()), 32'd6);
    for (int i = 0; i < 5 && i < int'(got.size()); i++)
      chk("short_beat", got[i], beat(i + 1, i == 0, 1'b0));
    if (got.size() > 5) chk("short_filler", got[5], beat(0, 1'b0, 1'b1));
    chk("short_fe", 32'(fe), 32'd1);
    pulse_clear();
    chk("short_fe_cleared", 32'(fe), 32'd0);

    // Long frame, then a following normal frame
    got.delete();
    run_frame(10, 1'b1, 0, 1'b0);
    idle(5);
    check_full_packet("long");
    chk("long_fe", 32'(fe), 32'd1);
    pulse_clear();
    got.delete();
    run_frame(8, 1'b1, 0, 1'b0);
    idle(5);
    check_full_packet("after_long");

    // Reset mid-frame
    got.delete();
    rdy = 1'b0;
    run_frame(3, 1'b1, 0, 1'b1);
    chk("pre_rst_valid", 32'(valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 32'(valid), 32'd0);
    model_reset();
    idle(2);
    rst = 1'b0;
    rdy = 1'b1;
    pv  = 1'b1;
    pd  = DW'(30'h3ff);
    repeat (3) cycle();
    pv = 1'b0;
    chk("post_rst_no_beats", 32'(got.size()), 32'd0);
    fv = 1'b0;
    idle(2);
    run_frame(8, 1'b1, 0, 1'b0);
    idle(5);
    check_full_packet("post_rst");

    // Clear racing a new overflow
    got.delete();
    rdy = 1'b0;
    run_frame(4, 1'b1, 0, 1'b1);
    pv  = 1'b1;
    pd  = DW'(5);
    clr = 1'b1;
    cycle();
    clr = 1'b0;
    pv  = 1'b0;
    chk("race_ov_set_wins", 32'(ov), 32'd1);
    rdy = 1'b1;
    idle(6);
    fv = 1'b0;
    idle(2);
    chk("race_ov_held", 32'(ov), 32'd1);
    pulse_clear();
    chk("race_ov_cleared", 32'(ov), 32'd0);
    chk("race_beats", 32'(got.size()), 32'd5);

    // Randomized frames, gaps, backpressure and clears
    rnd_rdy = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int n;
      n = ($urandom_range(0, 3) == 0) ? TOTAL : $urandom_range(0, TOTAL + 3);
      idle($urandom_range(1, 3));
      run_frame(n, 1'b0, $urandom_range(0, 2), 1'b0);
      if ($urandom_range(0, 3) == 0) pulse_clear();
    end
    rnd_rdy = 1'b0;
    rdy = 1'b1;
    idle(10);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_stream_source.md
Name: cam_stream_source

Overview:
- Converts a raw camera pixel bus into an Avalon-ST video packet stream: one packet per frame, 30-bit RGB (10:10:10).
- Drives the upstream end of the scaler sink stream (startofpacket / endofpacket / valid / ready / data[29:0]).
- Tags SOP on the first pixel and EOP on the last pixel of each frame.
- Absorbs sink backpressure in a show-ahead FIFO; closes truncated frames cleanly so the downstream scaler always receives a terminated packet.

Parameters:
- FRAME_WIDTH, 640, pixels per line.
- FRAME_HEIGHT, 480, lines per frame; TOTAL = FRAME_WIDTH*FRAME_HEIGHT.
- FIFO_DEPTH, 16, FIFO entries; power of two, minimum 4.
- DATA_WIDTH, 30, pixel width.

Ports:
- clk_clk  in  1  system clock; all logic on rising edge.
- reset_reset  in  1  asynchronous, active-high reset.
- cam_frame_valid  in  1  high for the duration of a frame.
- cam_pixel_valid  in  1  pixel qualifier.
- cam_pixel_data  in  30  RGB pixel.
- src_startofpacket  out  1  head beat is the first pixel of a frame.
- src_endofpacket  out  1  head beat is the last beat of a frame.
- src_valid  out  1  FIFO not empty.
- src_ready  in  1  sink accepts the beat.
- src_data  out  30  head beat data.
- clear_status  in  1  one-cycle pulse; clears the sticky flags.
- overflow  out  1  sticky; a pixel arrived while the FIFO was full.
- frame_error  out  1  sticky; frame shorter or longer than TOTAL.

Behaviour:
- Reset state: src_valid=0, src_startofpacket=0, src_endofpacket=0, src_data=0, overflow=0, frame_error=0. FIFO is emptied, pixel count is 0, state is WAIT_LOW.
- Edge detect: cam_frame_valid_d is a registered copy of cam_frame_valid, reset to 1. A frame already in progress at reset release is therefore never captured.
- FSM states and transitions:
  - WAIT_LOW: go to ARMED when cam_frame_valid=0.
  - ARMED: go to STREAM on a rising edge; the pixel in the same cycle as the rising edge is captured.
  - STREAM: each cycle with cam_frame_valid & cam_pixel_valid is one pixel.
    - If the FIFO is not full: write {data, sop=(count==0), eop=(count==TOTAL-1)} and increment count.
    - If count==TOTAL-1 is written: go to WAIT_END.
    - If the FIFO is full on a pixel: overflow<=1, discard the pixel, go to CLOSE.
    - If cam_frame_valid falls with 0<count<TOTAL: frame_error<=1, go to CLOSE.
    - If cam_frame_valid falls with count==0: go to ARMED; no beats are written.
  - CLOSE: when the FIFO is not full, write a filler beat {data=0, sop=0, eop=1}, clear count, go to WAIT_END.
  - WAIT_END: discard all pixels. Any valid pixel seen here after a complete frame sets frame_error (long frame). Go to ARMED when cam_frame_valid=0.
- FIFO write rule: a write requires !full, regardless of a pop in the same cycle.
- FIFO read rule: pop when src_valid & src_ready. src_* are driven from the head entry with registered pointers (show-ahead). src_data, src_startofpacket and src_endofpacket are held stable while src_valid=1 and src_ready=0.
- Latency: a pixel written at edge N appears on src_* in cycle N+1 if the FIFO was empty.
- Pointers: wrap modulo FIFO_DEPTH, with an extra MSB to distinguish full from empty.
- Pixel counter: width clog2(TOTAL).
- Sticky flags: set by the events above, cleared by clear_status. If set and clear occur in the same cycle, set wins.
- Reset mid-operation: takes effect immediately (asynchronous). Partial FIFO content is lost; no EOP is emitted for the lost frame.

Test Plan:
Bench parameters: FRAME_WIDTH=4, FRAME_HEIGHT=2, FIFO_DEPTH=4.
- Normal frame: 8 pixels 0x001..0x008, src_ready=1 -> 8 beats in order; SOP only on 0x001, EOP only on 0x008; flags stay 0.
- Backpressure overflow: src_ready=0, pixels 1..5 -> FIFO holds 1..4, overflow=1; then src_ready=1 -> beats 1(SOP),2,3,4, then filler 0x000 with EOP; 5 beats total.
- Short frame: frame_valid falls after 5 pixels -> beats 1..5 (SOP on 1), filler 0 with EOP; frame_error=1.
- Long frame: 10 pixels -> 8 beats with EOP on 8th; pixels 9 and 10 are dropped; frame_error=1; next frame starts with SOP.
- Reset mid-frame: reset after 3 pixels, released with frame_valid still high -> src_valid=0 at once; no beats until the next low-then-high frame, which emits a full 8-beat packet.
- Status clear race: clear_status pulsed in the same cycle as a new overflow -> overflow stays 1; a later clear alone -> overflow=0.
